// File: rtl/wb_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage_pkg
// Purpose  : Shared definitions for the writeback stage. Contains the
//            machine-mode CSR addresses, the CSR op codes, exception cause
//            codes, mstatus bit positions and the read-modify-write helpers.
// Revision : 1.0  initial release
// ============================================================================
package wb_stage_pkg;

  // Machine-mode CSR addresses
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  // CSR operation carried down the pipe with each Zicsr instruction
  typedef enum logic [1:0] {
    CORE_CSR_NOP   = 2'd0,
    CORE_CSR_WRITE = 2'd1,
    CORE_CSR_SET   = 2'd2,
    CORE_CSR_CLEAR = 2'd3
  } csr_op_e;

  // Exception cause codes (interrupt bit clear)
  localparam logic [31:0] CAUSE_INSTR_ADDR_MISALIGNED = 32'd0;
  localparam logic [31:0] CAUSE_ILLEGAL_INSTR         = 32'd2;

  // mstatus fields
  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MSTATUS_MPP_LSB  = 11;

  // Trap request handed from the stage to the CSR file
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] cause;
    logic [31:0] tval;
  } trap_req_t;

  // New CSR value produced by a Zicsr op applied to the current value
  function automatic logic [31:0] csr_rmw(input csr_op_e op,
                                          input logic [31:0] old_val,
                                          input logic [31:0] operand);
    case (op)
      CORE_CSR_WRITE: return operand;
      CORE_CSR_SET:   return old_val | operand;
      CORE_CSR_CLEAR: return old_val & ~operand;
      default:        return old_val;
    endcase
  endfunction

  // SET/CLEAR with a zero operand are pure reads and must not cause a write
  function automatic logic csr_op_writes(input csr_op_e op,
                                         input logic [31:0] operand);
    return (op == CORE_CSR_WRITE) ||
           (((op == CORE_CSR_SET) || (op == CORE_CSR_CLEAR)) && (operand != 32'd0));
  endfunction

endpackage : wb_stage_pkg
`default_nettype wire

// File: rtl/wb_stage_csr_file.sv
`default_nettype none
// ============================================================================
// Module   : wb_csr_file
// Purpose  : Machine-mode CSR storage for the writeback stage: read mux,
//            read-modify-write, mcycle/minstret counters and the trap-entry
//            and mret state updates. All state changes land on the clock
//            edge after the instruction sits in WB; reads are combinational
//            and therefore return the pre-update value.
// Revision : 1.0  initial release
// ============================================================================
module wb_csr_file
  import wb_stage_pkg::*;
#(
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
  parameter logic [31:0] HART_ID   = 32'd0,
  parameter bit          CNT_EN    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] i_addr,
  output logic [31:0] o_rdata,
  input  logic        i_wr_req,      // retiring instruction carries a CSR op
  input  csr_op_e     i_wr_op,
  input  logic [31:0] i_wr_operand,
  input  trap_req_t   i_trap,
  input  logic        i_mret,        // retiring, non-excepting mret
  input  logic        i_retire,      // valid, non-excepting instruction
  output logic [31:0] o_mtvec,
  output logic [31:0] o_mepc
);

  logic        r_mie;
  logic        r_mpie;
  logic [31:0] r_mtvec;
  logic [31:0] r_mscratch;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic [31:0] r_mtval;
  logic [63:0] w_mcycle;
  logic [63:0] w_minstret;

  logic [31:0] w_mstatus;
  logic [31:0] w_new;
  logic        w_wr;
  logic        w_wr_mstatus;
  logic        w_wr_mtvec;
  logic        w_wr_mscratch;
  logic        w_wr_mepc;
  logic        w_wr_mcause;
  logic        w_wr_mtval;
  logic        w_wr_mcycle;
  logic        w_wr_mcycleh;
  logic        w_wr_minstret;
  logic        w_wr_minstreth;

  // mstatus view: MPP is hardwired to machine mode, only MIE/MPIE are live
  always_comb begin
    w_mstatus                                        = 32'd0;
    w_mstatus[MSTATUS_MPP_LSB+1:MSTATUS_MPP_LSB]     = 2'b11;
    w_mstatus[MSTATUS_MPIE_BIT]                      = r_mpie;
    w_mstatus[MSTATUS_MIE_BIT]                       = r_mie;
  end

  // Combinational read mux; unimplemented addresses read as zero
  always_comb begin
    o_rdata = 32'd0;
    case (i_addr)
      CSR_MSTATUS:   o_rdata = w_mstatus;
      CSR_MTVEC:     o_rdata = r_mtvec;
      CSR_MSCRATCH:  o_rdata = r_mscratch;
      CSR_MEPC:      o_rdata = r_mepc;
      CSR_MCAUSE:    o_rdata = r_mcause;
      CSR_MTVAL:     o_rdata = r_mtval;
      CSR_MCYCLE:    o_rdata = w_mcycle[31:0];
      CSR_MCYCLEH:   o_rdata = w_mcycle[63:32];
      CSR_MINSTRET:  o_rdata = w_minstret[31:0];
      CSR_MINSTRETH: o_rdata = w_minstret[63:32];
      CSR_MHARTID:   o_rdata = HART_ID;
      default:       o_rdata = 32'd0;
    endcase
  end

  assign w_new = csr_rmw(i_wr_op, o_rdata, i_wr_operand);
  assign w_wr  = i_wr_req && csr_op_writes(i_wr_op, i_wr_operand);

  // Per-register write strobes; mhartid and unknown addresses get none
  always_comb begin
    w_wr_mstatus   = w_wr && (i_addr == CSR_MSTATUS);
    w_wr_mtvec     = w_wr && (i_addr == CSR_MTVEC);
    w_wr_mscratch  = w_wr && (i_addr == CSR_MSCRATCH);
    w_wr_mepc      = w_wr && (i_addr == CSR_MEPC);
    w_wr_mcause    = w_wr && (i_addr == CSR_MCAUSE);
    w_wr_mtval     = w_wr && (i_addr == CSR_MTVAL);
    w_wr_mcycle    = w_wr && (i_addr == CSR_MCYCLE);
    w_wr_mcycleh   = w_wr && (i_addr == CSR_MCYCLEH);
    w_wr_minstret  = w_wr && (i_addr == CSR_MINSTRET);
    w_wr_minstreth = w_wr && (i_addr == CSR_MINSTRETH);
  end

  // mstatus interrupt-enable stack: trap pushes, mret pops, CSR write last
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mie  <= 1'b0;
      r_mpie <= 1'b0;
    end else if (i_trap.valid) begin
      r_mpie <= r_mie;
      r_mie  <= 1'b0;
    end else if (i_mret) begin
      r_mie  <= r_mpie;
      r_mpie <= 1'b1;
    end else if (w_wr_mstatus) begin
      r_mie  <= w_new[MSTATUS_MIE_BIT];
      r_mpie <= w_new[MSTATUS_MPIE_BIT];
    end
  end

  // Trap-handling registers; trap capture and CSR writes never coincide
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mtvec    <= {MTVEC_RST[31:2], 2'b00};
      r_mscratch <= 32'd0;
      r_mepc     <= 32'd0;
      r_mcause   <= 32'd0;
      r_mtval    <= 32'd0;
    end else begin
      if (w_wr_mtvec)    r_mtvec    <= {w_new[31:2], 2'b00};
      if (w_wr_mscratch) r_mscratch <= w_new;
      if (i_trap.valid) begin
        r_mepc   <= {i_trap.pc[31:2], 2'b00};
        r_mcause <= i_trap.cause;
        r_mtval  <= i_trap.tval;
      end else begin
        if (w_wr_mepc)   r_mepc   <= {w_new[31:2], 2'b00};
        if (w_wr_mcause) r_mcause <= w_new;
        if (w_wr_mtval)  r_mtval  <= w_new;
      end
    end
  end

  generate
    if (CNT_EN) begin : g_cnt
      logic [63:0] r_mcycle;
      logic [63:0] r_minstret;
      logic [63:0] w_mcycle_inc;
      logic [63:0] w_minstret_nxt;

      // Full 64-bit increment so the low->high carry lands on the same edge
      always_comb begin
        w_mcycle_inc   = r_mcycle + 64'd1;
        w_minstret_nxt = i_retire ? (r_minstret + 64'd1) : r_minstret;
      end

      // A CSR write to one half replaces that half's increment only
      always_ff @(posedge clk) begin
        if (rst) begin
          r_mcycle   <= 64'd0;
          r_minstret <= 64'd0;
        end else begin
          r_mcycle[31:0]    <= w_wr_mcycle    ? w_new : w_mcycle_inc[31:0];
          r_mcycle[63:32]   <= w_wr_mcycleh   ? w_new : w_mcycle_inc[63:32];
          r_minstret[31:0]  <= w_wr_minstret  ? w_new : w_minstret_nxt[31:0];
          r_minstret[63:32] <= w_wr_minstreth ? w_new : w_minstret_nxt[63:32];
        end
      end

      assign w_mcycle   = r_mcycle;
      assign w_minstret = r_minstret;
    end else begin : g_no_cnt
      assign w_mcycle   = 64'd0;
      assign w_minstret = 64'd0;
    end
  endgenerate

  assign o_mtvec = r_mtvec;
  assign o_mepc  = r_mepc;

endmodule : wb_csr_file
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage
// Purpose  : Writeback stage. Resolves exception priority for the
//            instruction in WB, selects the register-file write data (ALU /
//            load result or CSR read value), and issues the PC redirect /
//            flush pulse for trap entry and mret. CSR state lives in
//            wb_csr_file.
// Revision : 1.0  initial release
// ============================================================================
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
  parameter logic [31:0] HART_ID   = 32'd0,
  parameter bit          CNT_EN    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem2wb_valid,
  input  logic [31:0] mem2wb_pc,
  input  logic [31:0] mem2wb_instruction,
  input  logic        mem2wb_reg_wen,
  input  logic [4:0]  mem2wb_reg_waddr,
  input  logic [31:0] mem2wb_reg_wdata,
  input  logic        mem2wb_csr_rd,
  input  logic [1:0]  mem2wb_csr_wr_op,
  input  logic [31:0] mem2wb_csr_wdata,
  input  logic [11:0] mem2wb_csr_addr,
  input  logic        mem2wb_sel_csr,
  input  logic        mem2wb_mret,
  input  logic        mem2wb_ill_instr,
  input  logic        mem2wb_exc_instr_addr_misaligned,
  output logic        wb_reg_wen,
  output logic [4:0]  wb_reg_waddr,
  output logic [31:0] wb_reg_wdata,
  output logic        wb_redirect,
  output logic [31:0] wb_redirect_pc
);

  logic        w_exc_misaligned;
  logic        w_exc_ill;
  logic        w_exc;
  logic        w_retire;
  logic        w_mret;
  logic        w_csr_wr_req;
  csr_op_e     w_csr_op;
  trap_req_t   w_trap;
  logic [31:0] w_csr_rdata;
  logic [31:0] w_csr_rd_val;
  logic [31:0] w_mtvec;
  logic [31:0] w_mepc;

  // Exception priority: misaligned fetch beats illegal instruction, and any
  // exception suppresses mret, CSR write and RF write of the same instruction
  always_comb begin
    w_exc_misaligned = mem2wb_valid && mem2wb_exc_instr_addr_misaligned;
    w_exc_ill        = mem2wb_valid && mem2wb_ill_instr && !mem2wb_exc_instr_addr_misaligned;
    w_exc            = w_exc_misaligned || w_exc_ill;
    w_retire         = mem2wb_valid && !w_exc;
    w_mret           = w_retire && mem2wb_mret;
    w_csr_op         = csr_op_e'(mem2wb_csr_wr_op);
    w_csr_wr_req     = w_retire && (w_csr_op != CORE_CSR_NOP);

    w_trap.valid     = w_exc;
    w_trap.pc        = mem2wb_pc;
    w_trap.cause     = w_exc_misaligned ? CAUSE_INSTR_ADDR_MISALIGNED : CAUSE_ILLEGAL_INSTR;
    w_trap.tval      = w_exc_misaligned ? mem2wb_pc : mem2wb_instruction;
  end

  wb_csr_file #(
    .MTVEC_RST (MTVEC_RST),
    .HART_ID   (HART_ID),
    .CNT_EN    (CNT_EN)
  ) u_csr_file (
    .clk          (clk),
    .rst          (rst),
    .i_addr       (mem2wb_csr_addr),
    .o_rdata      (w_csr_rdata),
    .i_wr_req     (w_csr_wr_req),
    .i_wr_op      (w_csr_op),
    .i_wr_operand (mem2wb_csr_wdata),
    .i_trap       (w_trap),
    .i_mret       (w_mret),
    .i_retire     (w_retire),
    .o_mtvec      (w_mtvec),
    .o_mepc       (w_mepc)
  );

  // The RF only sees a CSR value when the instruction actually reads it
  assign w_csr_rd_val = mem2wb_csr_rd ? w_csr_rdata : 32'd0;

  // RF write port and redirect; everything is held at zero during reset
  always_comb begin
    wb_reg_wen     = 1'b0;
    wb_reg_waddr   = 5'd0;
    wb_reg_wdata   = 32'd0;
    wb_redirect    = 1'b0;
    wb_redirect_pc = 32'd0;
    if (!rst) begin
      wb_reg_wen   = w_retire && mem2wb_reg_wen && (mem2wb_reg_waddr != 5'd0);
      wb_reg_waddr = mem2wb_reg_waddr;
      wb_reg_wdata = mem2wb_sel_csr ? w_csr_rd_val : mem2wb_reg_wdata;
      wb_redirect  = w_exc || w_mret;
      if (w_exc) begin
        wb_redirect_pc = {w_mtvec[31:2], 2'b00};
      end else if (w_mret) begin
        wb_redirect_pc = w_mepc;
      end
    end
  end

endmodule : wb_stage
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_stage
// Purpose  : Directed self-checking bench for wb_stage. CSR contents are
//            observed by issuing csrrs with a zero operand (a pure read)
//            and sampling the RF write data.
// Revision : 1.0  initial release
// ============================================================================
module tb_wb_stage;
  import wb_stage_pkg::*;

  logic        clk;
  logic        rst;
  logic        mem2wb_valid;
  logic [31:0] mem2wb_pc;
  logic [31:0] mem2wb_instruction;
  logic        mem2wb_reg_wen;
  logic [4:0]  mem2wb_reg_waddr;
  logic [31:0] mem2wb_reg_wdata;
  logic        mem2wb_csr_rd;
  logic [1:0]  mem2wb_csr_wr_op;
  logic [31:0] mem2wb_csr_wdata;
  logic [11:0] mem2wb_csr_addr;
  logic        mem2wb_sel_csr;
  logic        mem2wb_mret;
  logic        mem2wb_ill_instr;
  logic        mem2wb_exc_instr_addr_misaligned;
  logic        wb_reg_wen;
  logic [4:0]  wb_reg_waddr;
  logic [31:0] wb_reg_wdata;
  logic        wb_redirect;
  logic [31:0] wb_redirect_pc;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_instret = 0;

  wb_stage #(
    .MTVEC_RST (32'h0000_0000),
    .HART_ID   (32'd0),
    .CNT_EN    (1'b1)
  ) dut (
    .clk                              (clk),
    .rst                              (rst),
    .mem2wb_valid                     (mem2wb_valid),
    .mem2wb_pc                        (mem2wb_pc),
    .mem2wb_instruction               (mem2wb_instruction),
    .mem2wb_reg_wen                   (mem2wb_reg_wen),
    .mem2wb_reg_waddr                 (mem2wb_reg_waddr),
    .mem2wb_reg_wdata                 (mem2wb_reg_wdata),
    .mem2wb_csr_rd                    (mem2wb_csr_rd),
    .mem2wb_csr_wr_op                 (mem2wb_csr_wr_op),
    .mem2wb_csr_wdata                 (mem2wb_csr_wdata),
    .mem2wb_csr_addr                  (mem2wb_csr_addr),
    .mem2wb_sel_csr                   (mem2wb_sel_csr),
    .mem2wb_mret                      (mem2wb_mret),
    .mem2wb_ill_instr                 (mem2wb_ill_instr),
    .mem2wb_exc_instr_addr_misaligned (mem2wb_exc_instr_addr_misaligned),
    .wb_reg_wen                       (wb_reg_wen),
    .wb_reg_waddr                     (wb_reg_waddr),
    .wb_reg_wdata                     (wb_reg_wdata),
    .wb_redirect                      (wb_redirect),
    .wb_redirect_pc                   (wb_redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic clear_in();
    mem2wb_valid                     = 1'b0;
    mem2wb_pc                        = 32'd0;
    mem2wb_instruction               = 32'd0;
    mem2wb_reg_wen                   = 1'b0;
    mem2wb_reg_waddr                 = 5'd0;
    mem2wb_reg_wdata                 = 32'd0;
    mem2wb_csr_rd                    = 1'b0;
    mem2wb_csr_wr_op                 = CORE_CSR_NOP;
    mem2wb_csr_wdata                 = 32'd0;
    mem2wb_csr_addr                  = 12'd0;
    mem2wb_sel_csr                   = 1'b0;
    mem2wb_mret                      = 1'b0;
    mem2wb_ill_instr                 = 1'b0;
    mem2wb_exc_instr_addr_misaligned = 1'b0;
  endtask

  // Commit the current WB contents and return to the falling edge with a bubble
  task automatic tick();
    if (rst) exp_instret = 0;
    else if (mem2wb_valid && !mem2wb_ill_instr && !mem2wb_exc_instr_addr_misaligned)
      exp_instret++;
    @(posedge clk);
    @(negedge clk);
    clear_in();
  endtask

  // Place a Zicsr instruction in WB without committing it
  task automatic csr_instr(input logic [1:0] op, input logic [11:0] a,
                           input logic [31:0] operand, input logic [4:0] rd);
    clear_in();
    mem2wb_valid     = 1'b1;
    mem2wb_pc        = 32'h0000_1000;
    mem2wb_reg_wen   = 1'b1;
    mem2wb_reg_waddr = rd;
    mem2wb_csr_rd    = 1'b1;
    mem2wb_sel_csr   = 1'b1;
    mem2wb_csr_wr_op = op;
    mem2wb_csr_addr  = a;
    mem2wb_csr_wdata = operand;
  endtask

  // csrrs x1, a, x0 : returns the current value of a CSR
  task automatic rd_csr(input logic [11:0] a, output logic [31:0] v);
    csr_instr(CORE_CSR_SET, a, 32'd0, 5'd1);
    #1 v = wb_reg_wdata;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_in();
    repeat (3) @(posedge clk);
    @(negedge clk);
    mem2wb_valid = 1'b1; mem2wb_ill_instr = 1'b1; mem2wb_reg_wen = 1'b1;
    mem2wb_reg_waddr = 5'd3; mem2wb_reg_wdata = 32'h1234_5678;
    #1;
    n_tests++;
    if ({wb_reg_wen, wb_redirect, wb_reg_waddr, wb_reg_wdata, wb_redirect_pc} !== 71'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: wen=%b redir=%b waddr=%0d wdata=%h rpc=%h, all required 0",
               wb_reg_wen, wb_redirect, wb_reg_waddr, wb_reg_wdata, wb_redirect_pc);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_bubbles();
    logic [31:0] v;
    int bad = 0;
    for (int i = 0; i < 10; i++) begin
      mem2wb_reg_wen = 1'b1; mem2wb_reg_waddr = 5'd3; mem2wb_mret = 1'b1;
      mem2wb_ill_instr = 1'b1;
      #1;
      if (wb_reg_wen !== 1'b0 || wb_redirect !== 1'b0) bad++;
      tick();
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bubble_no_effect: %0d bubble cycles wrote RF or redirected, required 0", bad);
    end
    rd_csr(CSR_MINSTRET, v);
    n_tests++;
    if (v !== 32'd0) begin n_fail++; $display("FAIL minstret_after_bubbles: got %h want 0", v); end
    rd_csr(CSR_MCYCLE, v);
    n_tests++;
    if (v !== 32'd11) begin n_fail++; $display("FAIL mcycle_after_bubbles: got %h want 0000000b", v); end
  endtask

  task automatic test_csr_rw();
    logic [31:0] v;
    csr_instr(CORE_CSR_WRITE, CSR_MSCRATCH, 32'hA5A5_0000, 5'd5);
    #1;
    n_tests++;
    if (wb_reg_wen !== 1'b1 || wb_reg_waddr !== 5'd5 || wb_reg_wdata !== 32'd0) begin
      n_fail++;
      $display("FAIL csrrw_rf: wen=%b waddr=%0d wdata=%h want 1/5/00000000",
               wb_reg_wen, wb_reg_waddr, wb_reg_wdata);
    end
    tick();
    csr_instr(CORE_CSR_SET, CSR_MSCRATCH, 32'h0000_00FF, 5'd6);
    #1;
    n_tests++;
    if (wb_reg_wdata !== 32'hA5A5_0000) begin
      n_fail++; $display("FAIL csrrs_old_value: got %h want a5a50000", wb_reg_wdata);
    end
    tick();
    rd_csr(CSR_MSCRATCH, v);
    n_tests++;
    if (v !== 32'hA5A5_00FF) begin n_fail++; $display("FAIL mscratch_set: got %h want a5a500ff", v); end
    csr_instr(CORE_CSR_CLEAR, CSR_MSCRATCH, 32'h0000_00F0, 5'd0);
    #1;
    n_tests++;
    if (wb_reg_wen !== 1'b0) begin n_fail++; $display("FAIL x0_no_write: wen=%b want 0", wb_reg_wen); end
    tick();
    rd_csr(CSR_MSCRATCH, v);
    n_tests++;
    if (v !== 32'hA5A5_000F) begin n_fail++; $display("FAIL mscratch_clear: got %h want a5a5000f", v); end
    csr_instr(CORE_CSR_WRITE, CSR_MHARTID, 32'h5555_5555, 5'd0);
    tick();
    rd_csr(CSR_MHARTID, v);
    n_tests++;
    if (v !== 32'd0) begin n_fail++; $display("FAIL mhartid_ro: got %h want 0", v); end
  endtask

  task automatic test_trap_ill();
    logic [31:0] v;
    int          ret_before;
    csr_instr(CORE_CSR_WRITE, CSR_MTVEC, 32'h8000_0103, 5'd0);
    tick();
    rd_csr(CSR_MTVEC, v);
    n_tests++;
    if (v !== 32'h8000_0100) begin n_fail++; $display("FAIL mtvec_mask: got %h want 80000100", v); end
    csr_instr(CORE_CSR_SET, CSR_MSTATUS, 32'h0000_0008, 5'd0);
    tick();
    rd_csr(CSR_MSTATUS, v);
    n_tests++;
    if (v !== 32'h0000_1808) begin n_fail++; $display("FAIL mstatus_mie_set: got %h want 00001808", v); end
    ret_before = exp_instret;
    clear_in();
    mem2wb_valid = 1'b1; mem2wb_pc = 32'h0000_0100; mem2wb_instruction = 32'hFFFF_FFFF;
    mem2wb_ill_instr = 1'b1; mem2wb_reg_wen = 1'b1; mem2wb_reg_waddr = 5'd7;
    #1;
    n_tests++;
    if (wb_redirect !== 1'b1 || wb_redirect_pc !== 32'h8000_0100 || wb_reg_wen !== 1'b0) begin
      n_fail++;
      $display("FAIL ill_redirect: redir=%b rpc=%h wen=%b want 1/80000100/0",
               wb_redirect, wb_redirect_pc, wb_reg_wen);
    end
    tick();
    rd_csr(CSR_MINSTRET, v);
    n_tests++;
    if (v !== 32'(ret_before)) begin n_fail++; $display("FAIL trap_no_retire: got %h want %h", v, ret_before); end
    rd_csr(CSR_MCAUSE, v);
    n_tests++;
    if (v !== 32'd2) begin n_fail++; $display("FAIL ill_mcause: got %h want 00000002", v); end
    rd_csr(CSR_MEPC, v);
    n_tests++;
    if (v !== 32'h0000_0100) begin n_fail++; $display("FAIL ill_mepc: got %h want 00000100", v); end
    rd_csr(CSR_MTVAL, v);
    n_tests++;
    if (v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL ill_mtval: got %h want ffffffff", v); end
    rd_csr(CSR_MSTATUS, v);
    n_tests++;
    if (v !== 32'h0000_1880) begin n_fail++; $display("FAIL ill_mstatus: got %h want 00001880", v); end
  endtask

  task automatic test_exc_priority();
    logic [31:0] v;
    csr_instr(CORE_CSR_WRITE, CSR_MSCRATCH, 32'hDEAD_BEEF, 5'd9);
    mem2wb_pc = 32'h0000_0202; mem2wb_instruction = 32'h1234_5678;
    mem2wb_exc_instr_addr_misaligned = 1'b1; mem2wb_ill_instr = 1'b1; mem2wb_mret = 1'b1;
    #1;
    n_tests++;
    if (wb_redirect !== 1'b1 || wb_redirect_pc !== 32'h8000_0100 || wb_reg_wen !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_redirect: redir=%b rpc=%h wen=%b want 1/80000100/0",
               wb_redirect, wb_redirect_pc, wb_reg_wen);
    end
    tick();
    rd_csr(CSR_MCAUSE, v);
    n_tests++;
    if (v !== 32'd0) begin n_fail++; $display("FAIL prio_mcause: got %h want 00000000", v); end
    rd_csr(CSR_MTVAL, v);
    n_tests++;
    if (v !== 32'h0000_0202) begin n_fail++; $display("FAIL prio_mtval: got %h want 00000202", v); end
    rd_csr(CSR_MEPC, v);
    n_tests++;
    if (v !== 32'h0000_0200) begin n_fail++; $display("FAIL prio_mepc: got %h want 00000200", v); end
    rd_csr(CSR_MSCRATCH, v);
    n_tests++;
    if (v !== 32'hA5A5_000F) begin n_fail++; $display("FAIL prio_csr_blocked: got %h want a5a5000f", v); end
  endtask

  task automatic test_mret();
    logic [31:0] v;
    int          ret_before;
    csr_instr(CORE_CSR_WRITE, CSR_MEPC, 32'h0000_0207, 5'd0);
    tick();
    csr_instr(CORE_CSR_WRITE, CSR_MSTATUS, 32'h0000_0080, 5'd0);
    tick();
    rd_csr(CSR_MEPC, v);
    n_tests++;
    if (v !== 32'h0000_0204) begin n_fail++; $display("FAIL mepc_mask: got %h want 00000204", v); end
    ret_before = exp_instret;
    clear_in();
    mem2wb_valid = 1'b1; mem2wb_pc = 32'h0000_0300; mem2wb_mret = 1'b1;
    #1;
    n_tests++;
    if (wb_redirect !== 1'b1 || wb_redirect_pc !== 32'h0000_0204) begin
      n_fail++;
      $display("FAIL mret_redirect: redir=%b rpc=%h want 1/00000204", wb_redirect, wb_redirect_pc);
    end
    tick();
    rd_csr(CSR_MINSTRET, v);
    n_tests++;
    if (v !== 32'(ret_before + 1)) begin n_fail++; $display("FAIL mret_retires: got %h want %h", v, ret_before + 1); end
    rd_csr(CSR_MSTATUS, v);
    n_tests++;
    if (v !== 32'h0000_1888) begin n_fail++; $display("FAIL mret_mstatus: got %h want 00001888", v); end
  endtask

  task automatic test_counter_wrap();
    logic [31:0] v;
    csr_instr(CORE_CSR_WRITE, CSR_MCYCLEH, 32'hFFFF_FFFF, 5'd0);
    tick();
    csr_instr(CORE_CSR_WRITE, CSR_MCYCLE, 32'hFFFF_FFFE, 5'd0);
    tick();
    rd_csr(CSR_MCYCLEH, v);
    n_tests++;
    if (v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mcycleh_written: got %h want ffffffff", v); end
    rd_csr(CSR_MCYCLE, v);
    n_tests++;
    if (v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mcycle_all_ones: got %h want ffffffff", v); end
    rd_csr(CSR_MCYCLEH, v);
    n_tests++;
    if (v !== 32'd0) begin n_fail++; $display("FAIL mcycleh_wrap: got %h want 00000000", v); end
    rd_csr(CSR_MCYCLE, v);
    n_tests++;
    if (v !== 32'd1) begin n_fail++; $display("FAIL mcycle_after_wrap: got %h want 00000001", v); end
    csr_instr(CORE_CSR_WRITE, CSR_MCYCLE, 32'd5, 5'd0);
    tick();
    rd_csr(CSR_MCYCLE, v);
    n_tests++;
    if (v !== 32'd5) begin n_fail++; $display("FAIL mcycle_write_wins: got %h want 00000005", v); end
  endtask

  task automatic test_rst_mid_trap();
    logic [31:0] v;
    clear_in();
    rst = 1'b1;
    mem2wb_valid = 1'b1; mem2wb_pc = 32'h0000_0400; mem2wb_ill_instr = 1'b1;
    #1;
    n_tests++;
    if (wb_redirect !== 1'b0 || wb_redirect_pc !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_trap_redirect: redir=%b rpc=%h want 0/00000000", wb_redirect, wb_redirect_pc);
    end
    tick();
    rst = 1'b0;
    rd_csr(CSR_MINSTRET, v);
    n_tests++;
    if (v !== 32'd0) begin n_fail++; $display("FAIL rst_minstret: got %h want 0", v); end
    rd_csr(CSR_MEPC, v);
    n_tests++;
    if (v !== 32'd0) begin n_fail++; $display("FAIL rst_mepc: got %h want 00000000", v); end
    rd_csr(CSR_MTVEC, v);
    n_tests++;
    if (v !== 32'd0) begin n_fail++; $display("FAIL rst_mtvec: got %h want 00000000", v); end
    rd_csr(CSR_MSTATUS, v);
    n_tests++;
    if (v !== 32'h0000_1800) begin n_fail++; $display("FAIL rst_mstatus: got %h want 00001800", v); end
  endtask

  initial begin
    test_reset();
    test_bubbles();
    test_csr_rw();
    test_trap_ill();
    test_exc_priority();
    test_mret();
    test_counter_wrap();
    test_rst_mid_trap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_wb_stage
`default_nettype wire
